ysyx_22040237_ifu: RTL and testbench
====================================

# ysyx_22040237_ifu

Instruction fetch unit for the ysyx_22040237 single-cycle core; sits directly upstream of the decode stage. It owns the PC register and issues one word fetch at a time to instruction memory over a request/response handshake. It presents the fetched `pc`/`inst` pair to decode with a valid/ready handshake, and applies PC redirects coming back from jump resolution, discarding any fetch made stale by a redirect.

## Interface
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `mem_req_valid`  out  1  fetch request valid.
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_req_addr`  out  32  word-aligned fetch address.
- `mem_resp_valid`  in  1  response data valid (exactly one per accepted request).
- `mem_resp_data`  in  32  fetched instruction word.
- `redirect_valid`  in  1  jump taken; load `redirect_target` into the PC.
- `redirect_target`  in  32  new PC; bits [1:0] are ignored and treated as 0.
- `inst_valid`  out  1  `pc`/`inst` hold a valid instruction for decode.
- `inst_ready`  in  1  decode consumes the instruction this cycle.
- `pc`  out  32  address of the presented instruction.
- `inst`  out  32  presented instruction word.
- `fetch_cnt`  out  64  count of instructions handed to decode.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: `pc_r`, `inst_r`, `kill`, `fetch_cnt`.
- IDLE: no outputs asserted; unconditionally go to REQ on the next edge.
- REQ: `mem_req_valid`=1 and `mem_req_addr`=`pc_r`.
  - `mem_req_ready`=1: go to WAIT.
  - If `redirect_valid` is also high that cycle, load `pc_r`=target and set `kill`=1.
  - `mem_req_ready`=0 with `redirect_valid`=1: load `pc_r`=target and stay in REQ; the address changes before acceptance, which the memory interface permits.
- WAIT: `mem_req_valid`=0.
  - `redirect_valid`=1: load `pc_r`=target and set `kill`=1; the state is unchanged.
  - `mem_resp_valid`=1 with `kill`=1 (including a kill set in the same cycle): discard the data, clear `kill`, go to REQ.
  - `mem_resp_valid`=1 with `kill`=0: `inst_r`=data, go to HOLD.
- HOLD: `inst_valid`=1, `pc`=`pc_r`, `inst`=`inst_r`.
  - `inst_ready`=1: `fetch_cnt`+=1; `pc_r`=target if `redirect_valid`, else `pc_r`+4; go to REQ.
  - `inst_ready`=0 with `redirect_valid`=1: drop the held instruction without counting it, `pc_r`=target, go to REQ.
  - Otherwise hold all values stable.
- PC arithmetic is modulo 2^32: `pc_r`+4 wraps from 32'hFFFF_FFFC to 0.
- `fetch_cnt` is modulo 2^64.
- `pc`/`inst` outputs always reflect `pc_r`/`inst_r`; they are meaningful only while `inst_valid`=1.

## Timing
- Reset values:
  - state=IDLE, `pc_r`=`RESET_PC`, `inst_r`=0, `kill`=0, `fetch_cnt`=0.
  - `mem_req_valid`=0, `inst_valid`=0, `mem_req_addr`=`RESET_PC`, `pc`=`RESET_PC`, `inst`=0.
- Reset asserted mid-operation returns immediately to IDLE, aborting any outstanding response. The memory model is reset by the same `rst`.
- First request is visible in the second cycle after reset deassertion (IDLE takes one cycle).
- Zero-wait memory (ready in cycle n, resp in cycle n+1): `inst_valid` rises in cycle n+2, and the next request is issued in the cycle after `inst_ready`. Peak throughput is 1 instruction per 3 cycles.
- Only one request is outstanding at a time; `mem_req_valid` is never asserted in WAIT or HOLD.
- `inst_valid` stays high with stable `pc`/`inst` until consumed or redirected.
- No combinational path from `mem_resp_*` or `inst_ready` to `mem_req_*`; all outputs are driven from registers or the state decode.

## Test plan
- **Reset fetch:** reset, then zero-wait memory returning 32'h0010_0093 → request address 32'h8000_0000 in cycle 2, `inst_valid`=1 with `pc`=32'h8000_0000 and `inst`=32'h0010_0093 in cycle 4; with `inst_ready`=1, the next request goes to 32'h8000_0004 and `fetch_cnt`=1.
- **Backpressure:** hold `inst_ready`=0 for 5 cycles in HOLD → `pc`/`inst` stable, no new `mem_req_valid`; release → exactly one increment of `fetch_cnt`.
- **Redirect on accept:** in HOLD, assert `inst_ready`=1, `redirect_valid`=1, target 32'h8000_0103 → next request address 32'h8000_0100.
- **Stale-fetch kill:** redirect to 32'h8000_0200 during WAIT, memory stalls 3 cycles then responds → response discarded, `inst_valid` stays 0, next request to 32'h8000_0200, `fetch_cnt` unchanged.
- **Same-edge redirect:** redirect in the same cycle as `mem_req_ready`=1 in REQ → the returned word is discarded and the next request goes to the target.
- **Wrap and async reset:** with `RESET_PC`=32'hFFFF_FFFC, accept one instruction → next request to 32'h0000_0000. Then assert `rst` asynchronously mid-WAIT → `mem_req_valid`/`inst_valid` drop to 0 before the next clock edge and `pc`=`RESET_PC`.

Source files
------------

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time, hands pc/inst to decode.
// Holds at most one outstanding request; a redirect marks an in-flight fetch stale.
module ysyx_22040237_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        kill_q;
  logic [63:0] cnt_q;

  logic [31:0] tgt;
  logic [31:0] pc_seq_d;

  assign tgt      = redirect_target & 32'hFFFF_FFFC;
  assign pc_seq_d = redirect_valid ? tgt : pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      kill_q  <= 1'b0;
      cnt_q   <= 64'd0;
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (redirect_valid) pc_q <= tgt;
          if (mem_req_ready) begin
            state_q <= S_WAIT;
            if (redirect_valid) kill_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_q   <= tgt;
            kill_q <= 1'b1;
          end
          // A redirect on the response cycle kills this response as well.
          if (mem_resp_valid) begin
            if (kill_q || redirect_valid) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q  <= mem_resp_data;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            cnt_q   <= cnt_q + 64'd1;
            pc_q    <= pc_seq_d;
            state_q <= S_REQ;
          end else if (redirect_valid) begin
            pc_q    <= tgt;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = pc_q;
  assign inst_valid    = (state_q == S_HOLD);
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed bench for ysyx_22040237_ifu: cycle-scripted memory and decode with hand-computed expectations.
module tb_ysyx_22040237_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_w;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_ready;

  logic        mem_req_valid, inst_valid;
  logic [31:0] mem_req_addr, pc, inst;
  logic [63:0] fetch_cnt;

  logic        mem_req_valid_w, inst_valid_w;
  logic [31:0] mem_req_addr_w, pc_w, inst_w;
  logic [63:0] fetch_cnt_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040237_ifu u_dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc(pc), .inst(inst), .fetch_cnt(fetch_cnt)
  );

  ysyx_22040237_ifu #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst_w),
    .mem_req_valid(mem_req_valid_w), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr_w),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid_w), .inst_ready(inst_ready),
    .pc(pc_w), .inst(inst_w), .fetch_cnt(fetch_cnt_w)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
    redirect_valid = 1'b0; redirect_target = 32'd0; inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Cycle 1 after reset: IDLE with reset values
    chk("rst_req_vld", 64'(mem_req_valid), 64'd0);
    chk("rst_inst_vld", 64'(inst_valid), 64'd0);
    chk("rst_addr", 64'(mem_req_addr), 64'h8000_0000);
    chk("rst_pc", 64'(pc), 64'h8000_0000);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_cnt", fetch_cnt, 64'd0);

    tick();  // cycle 2: REQ
    chk("c2_req_vld", 64'(mem_req_valid), 64'd1);
    chk("c2_addr", 64'(mem_req_addr), 64'h8000_0000);
    tick();  // cycle 3: WAIT, zero-wait response
    chk("c3_req_vld", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0093;
    tick();  // cycle 4: HOLD
    mem_resp_valid = 1'b0; mem_resp_data = 32'hDEAD_BEEF;
    chk("c4_inst_vld", 64'(inst_valid), 64'd1);
    chk("c4_pc", 64'(pc), 64'h8000_0000);
    chk("c4_inst", 64'(inst), 64'h0010_0093);

    // Backpressure: 5 cycles of inst_ready=0
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_inst_vld", 64'(inst_valid), 64'd1);
      chk("bp_req_vld", 64'(mem_req_valid), 64'd0);
      chk("bp_pc", 64'(pc), 64'h8000_0000);
      chk("bp_inst", 64'(inst), 64'h0010_0093);
    end
    chk("bp_cnt", fetch_cnt, 64'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("acc_req_vld", 64'(mem_req_valid), 64'd1);
    chk("acc_addr", 64'(mem_req_addr), 64'h8000_0004);
    chk("acc_inst_vld", 64'(inst_valid), 64'd0);
    chk("acc_cnt", fetch_cnt, 64'd1);

    // Second fetch, then redirect on accept to an unaligned target
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0020_0113;
    tick();
    mem_resp_valid = 1'b0;
    chk("f2_pc", 64'(pc), 64'h8000_0004);
    chk("f2_inst", 64'(inst), 64'h0020_0113);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h8000_0103;
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    chk("rda_addr", 64'(mem_req_addr), 64'h8000_0100);
    chk("rda_cnt", fetch_cnt, 64'd2);

    // Stale-fetch kill: redirect during WAIT, 3-cycle stall
    tick();  // WAIT for 0x100
    redirect_valid = 1'b1; redirect_target = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("kill_stall_req", 64'(mem_req_valid), 64'd0);
      chk("kill_stall_ivld", 64'(inst_valid), 64'd0);
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_0001;
    tick();
    mem_resp_valid = 1'b0;
    chk("kill_inst_vld", 64'(inst_valid), 64'd0);
    chk("kill_req_vld", 64'(mem_req_valid), 64'd1);
    chk("kill_addr", 64'(mem_req_addr), 64'h8000_0200);
    chk("kill_cnt", fetch_cnt, 64'd2);

    // Same-edge redirect with request acceptance
    redirect_valid = 1'b1; redirect_target = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_0002;
    tick();
    mem_resp_valid = 1'b0;
    chk("same_inst_vld", 64'(inst_valid), 64'd0);
    chk("same_addr", 64'(mem_req_addr), 64'h8000_0300);
    chk("same_req_vld", 64'(mem_req_valid), 64'd1);

    // Redirect while request not accepted: address changes, stays in REQ
    mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h8000_0407;
    tick();
    redirect_valid = 1'b0;
    chk("nrdy_req_vld", 64'(mem_req_valid), 64'd1);
    chk("nrdy_addr", 64'(mem_req_addr), 64'h8000_0404);
    mem_req_ready = 1'b1;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0030_0193;
    tick();
    mem_resp_valid = 1'b0;
    chk("nrdy_pc", 64'(pc), 64'h8000_0404);
    chk("nrdy_inst", 64'(inst), 64'h0030_0193);

    // Redirect in HOLD without consume: drop, no count
    redirect_valid = 1'b1; redirect_target = 32'h8000_0500;
    tick();
    redirect_valid = 1'b0;
    chk("drop_inst_vld", 64'(inst_valid), 64'd0);
    chk("drop_addr", 64'(mem_req_addr), 64'h8000_0500);
    chk("drop_cnt", fetch_cnt, 64'd2);

    // Wrap-around on the second instance, main held in reset
    rst = 1'b1;
    #1 chk("main_async_rst_req", 64'(mem_req_valid), 64'd0);
    rst_w = 1'b0;
    chk("w_rst_addr", 64'(mem_req_addr_w), 64'hFFFF_FFFC);
    tick();
    chk("w_req_vld", 64'(mem_req_valid_w), 64'd1);
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0040_0213;
    tick();
    mem_resp_valid = 1'b0;
    chk("w_pc", 64'(pc_w), 64'hFFFF_FFFC);
    chk("w_inst", 64'(inst_w), 64'h0040_0213);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("w_wrap_addr", 64'(mem_req_addr_w), 64'h0000_0000);
    chk("w_cnt", fetch_cnt_w, 64'd1);
    tick();  // WAIT
    chk("w_wait_req", 64'(mem_req_valid_w), 64'd0);
    #3 rst_w = 1'b1;
    #1;
    chk("w_arst_req", 64'(mem_req_valid_w), 64'd0);
    chk("w_arst_ivld", 64'(inst_valid_w), 64'd0);
    chk("w_arst_pc", 64'(pc_w), 64'hFFFF_FFFC);
    chk("w_arst_cnt", fetch_cnt_w, 64'd0);
    chk("w_arst_inst", 64'(inst_w), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
